fwrisc_writeback: RTL and testbench

FWRISC_WRITEBACK -- requirements
Module: fwrisc_writeback

---
 rtl/fwrisc_writeback_if.sv | 37 +++
 rtl/fwrisc_writeback.sv | 147 ++++++++++++++
 tb/tb_fwrisc_writeback.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_writeback_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_writeback_if
//  Purpose  : Bundles the writeback request handshake and the register-file
//             read/write ports used by fwrisc_writeback.
//  Revision : 1.0  initial release
// ============================================================================
interface fwrisc_writeback_if;
   // Upstream request
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [4:0]  req_rd;
   logic [5:0]  req_csr;
   logic [31:0] req_data;
   // Register-file read port (one-cycle read latency)
   logic [5:0]  rb_raddr;
   logic [31:0] rb_rdata;
   // Register-file write port and retirement
   logic [5:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        rd_wen;
   logic        instr_complete;

   // The writeback block itself
   modport slave (
      input  req_valid, req_op, req_rd, req_csr, req_data, rb_rdata,
      output req_ready, rb_raddr, rd_waddr, rd_wdata, rd_wen, instr_complete
   );

   // The environment: upstream pipeline plus register file
   modport master (
      output req_valid, req_op, req_rd, req_csr, req_data, rb_rdata,
      input  req_ready, rb_raddr, rd_waddr, rd_wdata, rd_wen, instr_complete
   );
endinterface
`default_nettype wire

// File: rtl/fwrisc_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : fwrisc_writeback
//  Purpose  : Retires GPR writebacks in one cycle and sequences CSR
//             read-modify-write operations (read, capture, write old value to
//             rd, write new value to the CSR) over four cycles.
//  Revision : 1.0  initial release
// ============================================================================
module fwrisc_writeback #(
   parameter bit ENABLE_CSR = 1'b1
) (
   input  wire logic            clock,
   input  wire logic            reset,
   fwrisc_writeback_if.slave    bus
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] CSR_RD   = 2'd1;
   localparam logic [1:0] CSR_CAP  = 2'd2;
   localparam logic [1:0] CSR_WR   = 2'd3;

   localparam logic [1:0] OP_WB    = 2'd0;
   localparam logic [1:0] OP_CSRRW = 2'd1;
   localparam logic [1:0] OP_CSRRS = 2'd2;
   localparam logic [1:0] OP_CSRRC = 2'd3;

   logic [1:0]  state_q,    state_d;
   logic [5:0]  rb_raddr_q, rb_raddr_d;
   logic [5:0]  rd_waddr_q, rd_waddr_d;
   logic [31:0] rd_wdata_q, rd_wdata_d;
   logic        rd_wen_q,   rd_wen_d;
   logic        complete_q, complete_d;
   logic [1:0]  op_q,       op_d;
   logic [4:0]  rd_q,       rd_d;
   logic [31:0] data_q,     data_d;
   logic [31:0] old_q,      old_d;
   logic [31:0] csr_new;

   // Only IDLE accepts; every CSR state stalls the upstream stage
   assign bus.req_ready      = (state_q == IDLE);
   assign bus.rb_raddr       = rb_raddr_q;
   assign bus.rd_waddr       = rd_waddr_q;
   assign bus.rd_wdata       = rd_wdata_q;
   assign bus.rd_wen         = rd_wen_q;
   assign bus.instr_complete = complete_q;

   // New CSR value from the captured old value and source operand
   always_comb begin
      csr_new = data_q;
      case (op_q)
         OP_CSRRS: csr_new = old_q | data_q;
         OP_CSRRC: csr_new = old_q & ~data_q;
         default:  csr_new = data_q;
      endcase
   end

   // Next-state logic; write strobes default low so they pulse for one cycle
   always_comb begin
      state_d    = state_q;
      rb_raddr_d = rb_raddr_q;
      rd_waddr_d = rd_waddr_q;
      rd_wdata_d = rd_wdata_q;
      rd_wen_d   = 1'b0;
      complete_d = 1'b0;
      op_d       = op_q;
      rd_d       = rd_q;
      data_d     = data_q;
      old_d      = old_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if ((bus.req_op == OP_WB) || !ENABLE_CSR) begin
                  // Single-cycle retire; x0 is never written.
                  // With CSR support removed, CSR ops retire with zero data.
                  rd_wen_d   = (bus.req_rd != 5'd0);
                  rd_waddr_d = {1'b0, bus.req_rd};
                  rd_wdata_d = (bus.req_op == OP_WB) ? bus.req_data : 32'd0;
                  complete_d = 1'b1;
               end else begin
                  rb_raddr_d = bus.req_csr;
                  op_d       = bus.req_op;
                  rd_d       = bus.req_rd;
                  data_d     = bus.req_data;
                  state_d    = CSR_RD;
               end
            end
         end

         // Register-file read is in flight this cycle
         CSR_RD: begin
            state_d = CSR_CAP;
         end

         // Read data is valid now: keep it and return it to rd
         CSR_CAP: begin
            old_d      = bus.rb_rdata;
            rd_wen_d   = (rd_q != 5'd0);
            rd_waddr_d = {1'b0, rd_q};
            rd_wdata_d = bus.rb_rdata;
            state_d    = CSR_WR;
         end

         // Set/clear with a zero mask leaves the CSR untouched, so skip the write
         CSR_WR: begin
            rd_wen_d   = (op_q == OP_CSRRW) || (data_q != 32'd0);
            rd_waddr_d = rb_raddr_q;
            rd_wdata_d = csr_new;
            complete_d = 1'b1;
            state_d    = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any CSR sequence in progress
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rb_raddr_q <= 6'd0;
         rd_waddr_q <= 6'd0;
         rd_wdata_q <= 32'd0;
         rd_wen_q   <= 1'b0;
         complete_q <= 1'b0;
         op_q       <= 2'd0;
         rd_q       <= 5'd0;
         data_q     <= 32'd0;
         old_q      <= 32'd0;
      end else begin
         state_q    <= state_d;
         rb_raddr_q <= rb_raddr_d;
         rd_waddr_q <= rd_waddr_d;
         rd_wdata_q <= rd_wdata_d;
         rd_wen_q   <= rd_wen_d;
         complete_q <= complete_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         old_q      <= old_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwrisc_writeback
//  Purpose  : Scoreboard bench for fwrisc_writeback: directed requests push
//             hand-computed write events; a monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwrisc_writeback;

   typedef struct {
      int          cyc;
      bit          wen;
      logic [5:0]  waddr;
      logic [31:0] wdata;
      bit          comp;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   int          cyc   = 0;
   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb[$];
   exp_t        e;
   logic [31:0] mem [64];

   fwrisc_writeback_if bus ();
   fwrisc_writeback_if bus2 ();

   fwrisc_writeback #(.ENABLE_CSR(1'b1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   fwrisc_writeback #(.ENABLE_CSR(1'b0)) dut_nocsr (
      .clock (clock),
      .reset (reset),
      .bus   (bus2)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Register-file model: one-cycle read latency
   always @(posedge clock) bus.rb_rdata <= mem[bus.rb_raddr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int c, input bit wen, input logic [5:0] wa,
                       input logic [31:0] wd, input bit comp);
      exp_t x;
      x.cyc = c; x.wen = wen; x.waddr = wa; x.wdata = wd; x.comp = comp;
      sb.push_back(x);
   endtask

   // Waits for ready, drives the request and returns the drive cycle
   task automatic start(input logic [1:0] op, input logic [4:0] rd,
                        input logic [5:0] csr, input logic [31:0] data, output int k);
      int guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      if (!bus.req_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: got 0x0 expected 0x1");
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rd    = rd;
      bus.req_csr   = csr;
      bus.req_data  = data;
      k = cyc;
   endtask

   task automatic finish_req();
      @(negedge clock);
      bus.req_valid = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clock) begin
      if (reset && (bus.rd_wen || bus.instr_complete)) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got wen=%0b addr=0x%0h data=0x%0h expected none",
                     bus.rd_wen, bus.rd_waddr, bus.rd_wdata);
         end else begin
            e = sb.pop_front();
            chk("event_cycle", 32'(cyc), 32'(e.cyc));
            chk("rd_wen", {31'd0, bus.rd_wen}, {31'd0, e.wen});
            chk("instr_complete", {31'd0, bus.instr_complete}, {31'd0, e.comp});
            if (e.wen) begin
               chk("rd_waddr", {26'd0, bus.rd_waddr}, {26'd0, e.waddr});
               chk("rd_wdata", bus.rd_wdata, e.wdata);
            end
         end
      end
   end

   initial begin
      int k;
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
      mem[6'h30] = 32'h0000_00F0;
      mem[6'h12] = 32'h0000_A5A5;
      mem[6'h3F] = 32'h0000_0055;
      mem[6'h21] = 32'h0000_0FFF;

      bus.req_valid  = 1'b0; bus.req_op  = 2'd0; bus.req_rd  = 5'd0;
      bus.req_csr    = 6'd0; bus.req_data = 32'd0;
      bus2.req_valid = 1'b0; bus2.req_op = 2'd0; bus2.req_rd = 5'd0;
      bus2.req_csr   = 6'd0; bus2.req_data = 32'd0; bus2.rb_rdata = 32'd0;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
      chk("rst_rb_raddr", {26'd0, bus.rb_raddr}, 32'd0);
      chk("rst_rd_wen", {31'd0, bus.rd_wen}, 32'd0);
      chk("rst_complete", {31'd0, bus.instr_complete}, 32'd0);
      chk("rst_rd_wdata", bus.rd_wdata, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // Single WB
      start(2'd0, 5'd5, 6'd0, 32'hDEAD_BEEF, k);
      push(k + 1, 1'b1, 6'h05, 32'hDEAD_BEEF, 1'b1);
      finish_req();

      // Three back-to-back WBs
      for (int i = 1; i <= 3; i++) begin
         chk("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
         start(2'd0, 5'(i), 6'd0, 32'(i * 17), k);
         push(k + 1, 1'b1, 6'(i), 32'(i * 17), 1'b1);
         @(negedge clock);
      end
      bus.req_valid = 1'b0;
      @(negedge clock);

      // WB to x0: no write, still retires
      start(2'd0, 5'd0, 6'd0, 32'h77, k);
      push(k + 1, 1'b0, 6'd0, 32'd0, 1'b1);
      finish_req();

      // CSRRS csr=0x30 (holds 0xF0), rd=7, data=0x0F
      start(2'd2, 5'd7, 6'h30, 32'h0F, k);
      push(k + 3, 1'b1, 6'h07, 32'hF0, 1'b0);
      push(k + 4, 1'b1, 6'h30, 32'hFF, 1'b1);
      finish_req();
      chk("csrrs_rb_raddr", {26'd0, bus.rb_raddr}, 32'h30);
      chk("csrrs_ready_n1", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clock);
      chk("csrrs_ready_n2", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clock);
      chk("csrrs_ready_n3", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clock);
      chk("csrrs_ready_n4", {31'd0, bus.req_ready}, 32'd1);

      // CSRRC data=0: rd gets old value, CSR write suppressed
      start(2'd3, 5'd4, 6'h12, 32'h0, k);
      push(k + 3, 1'b1, 6'h04, 32'hA5A5, 1'b0);
      push(k + 4, 1'b0, 6'd0, 32'd0, 1'b1);
      finish_req();

      // CSRRW rd=0: only the CSR write appears
      start(2'd1, 5'd0, 6'h3F, 32'h1234, k);
      push(k + 4, 1'b1, 6'h3F, 32'h1234, 1'b1);
      finish_req();

      // CSRRC with a real mask: 0xFFF & ~0x0F0 = 0xF0F
      start(2'd3, 5'd2, 6'h21, 32'h0F0, k);
      push(k + 3, 1'b1, 6'h02, 32'hFFF, 1'b0);
      push(k + 4, 1'b1, 6'h21, 32'hF0F, 1'b1);
      finish_req();
      chk("rb_raddr_hold", {26'd0, bus.rb_raddr}, 32'h21);

      // Reset during CSR_CAP aborts the sequence
      start(2'd1, 5'd9, 6'h30, 32'h1, k);
      finish_req();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_rd_wen", {31'd0, bus.rd_wen}, 32'd0);
      chk("abort_complete", {31'd0, bus.instr_complete}, 32'd0);
      chk("abort_rb_raddr", {26'd0, bus.rb_raddr}, 32'd0);
      chk("abort_rd_waddr", {26'd0, bus.rd_waddr}, 32'd0);
      chk("abort_rd_wdata", bus.rd_wdata, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
      repeat (5) @(negedge clock);

      // Normal operation resumes
      start(2'd0, 5'd6, 6'd0, 32'hCAFE, k);
      push(k + 1, 1'b1, 6'h06, 32'hCAFE, 1'b1);
      finish_req();

      // CSR support disabled: CSR op retires like WB with zero data
      bus2.req_valid = 1'b1;
      bus2.req_op    = 2'd2;
      bus2.req_rd    = 5'd3;
      bus2.req_csr   = 6'h20;
      bus2.req_data  = 32'h5;
      @(negedge clock);
      bus2.req_valid = 1'b0;
      chk("nocsr_rd_wen", {31'd0, bus2.rd_wen}, 32'd1);
      chk("nocsr_rd_waddr", {26'd0, bus2.rd_waddr}, 32'h03);
      chk("nocsr_rd_wdata", bus2.rd_wdata, 32'd0);
      chk("nocsr_complete", {31'd0, bus2.instr_complete}, 32'd1);
      chk("nocsr_rb_raddr", {26'd0, bus2.rb_raddr}, 32'd0);
      chk("nocsr_ready", {31'd0, bus2.req_ready}, 32'd1);

      repeat (6) @(negedge clock);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
